// File: rtl/nts_udp_payload_reader_if.sv
// nts_udp_payload_reader_if
// Payload word stream: valid/ready with last-word byte count.
interface nts_udp_payload_reader_if;
  logic        valid;
  logic        ready;
  logic [63:0] data;
  logic        last;
  logic [3:0]  last_bytes;

  modport master (
    output valid, data, last, last_bytes,
    input  ready
  );

  modport slave (
    input  valid, data, last, last_bytes,
    output ready
  );
endinterface

// File: rtl/nts_udp_payload_reader.sv
// nts_udp_payload_reader
// Reads the UDP payload from the packet buffer as realigned 64-bit words.
module nts_udp_payload_reader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_areset,
  input  logic                    i_clear,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH+2:0]   i_offset,
  input  logic [15:0]             i_udp_length,
  output logic                    o_busy,
  output logic                    o_error,
  output logic                    o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  input  logic [63:0]             i_ram_data,
  nts_udp_payload_reader_if.master o_stream,
  output logic                    o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HI,
    S_WAIT_HI,
    S_RD_LO,
    S_WAIT_LO,
    S_OUT
  } state_t;

  localparam int EW = (ADDR_WIDTH + 4 > 18) ? ADDR_WIDTH + 4 : 18;

  state_t                r_state, w_state_n;
  logic [63:0]           r_hi, w_hi_n;
  logic [63:0]           r_lo, w_lo_n;
  logic [15:0]           r_rem, w_rem_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [2:0]            r_b, w_b_n;
  logic                  r_error, w_error_n;
  logic                  r_done, w_done_n;

  logic [EW-1:0]         w_end;
  logic                  w_reject;
  logic [15:0]           w_span;
  logic [15:0]           w_rem_dec;
  logic                  w_need_lo;
  logic                  w_need_lo_dec;
  logic                  w_out;
  logic                  w_last;
  logic [127:0]          w_shift;
  logic [63:0]           w_mask;

  // last payload byte address, wide enough that it never wraps
  assign w_end = EW'(i_offset) + EW'(i_udp_length) - EW'(9);
  assign w_reject = (i_udp_length <= 16'd8) ||
                    ((w_end >> (ADDR_WIDTH + 3)) != '0);

  // bytes of the current word that still come from hi
  assign w_span        = 16'd8 - {13'd0, r_b};
  assign w_rem_dec     = r_rem - 16'd8;
  assign w_need_lo     = r_rem > w_span;
  assign w_need_lo_dec = w_rem_dec > w_span;

  assign w_shift = {r_hi, r_lo} << {r_b, 3'b000};
  assign w_mask  = (r_rem >= 16'd8) ? {64{1'b1}} :
                   ~({64{1'b1}} >> {r_rem[2:0], 3'b000});

  assign w_out  = (r_state == S_OUT);
  assign w_last = w_out && (r_rem <= 16'd8);

  assign o_busy      = (r_state != S_IDLE);
  assign o_error     = r_error;
  assign o_done      = r_done;
  assign o_ram_rd_en = (r_state == S_RD_HI) || (r_state == S_RD_LO);
  assign o_ram_addr  = r_addr;

  assign o_stream.valid      = w_out;
  assign o_stream.data       = w_out ? (w_shift[127:64] & w_mask) : '0;
  assign o_stream.last       = w_last;
  assign o_stream.last_bytes = w_last ? r_rem[3:0] : 4'd0;

  // next-state and datapath updates
  always_comb begin
    w_state_n = r_state;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_rem_n   = r_rem;
    w_addr_n  = r_addr;
    w_b_n     = r_b;
    w_error_n = 1'b0;
    w_done_n  = 1'b0;
    if (i_clear) begin
      w_state_n = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_reject) begin
              w_error_n = 1'b1;
            end else begin
              w_state_n = S_RD_HI;
              w_rem_n   = i_udp_length - 16'd8;
              w_b_n     = i_offset[2:0];
              w_addr_n  = i_offset[ADDR_WIDTH+2:3];
            end
          end
        end
        S_RD_HI: begin
          w_addr_n  = r_addr + 1'b1;
          w_state_n = S_WAIT_HI;
        end
        S_WAIT_HI: begin
          w_hi_n = i_ram_data;
          if (w_need_lo) begin
            w_state_n = S_RD_LO;
          end else begin
            w_lo_n    = '0;
            w_state_n = S_OUT;
          end
        end
        S_RD_LO: begin
          w_addr_n  = r_addr + 1'b1;
          w_state_n = S_WAIT_LO;
        end
        S_WAIT_LO: begin
          w_lo_n    = i_ram_data;
          w_state_n = S_OUT;
        end
        S_OUT: begin
          if (o_stream.ready) begin
            if (w_last) begin
              w_done_n  = 1'b1;
              w_state_n = S_IDLE;
            end else begin
              w_rem_n = w_rem_dec;
              w_hi_n  = r_lo;
              if (w_need_lo_dec) begin
                w_state_n = S_RD_LO;
              end else begin
                w_lo_n = '0;
              end
            end
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_addr  <= '0;
      r_b     <= '0;
      r_error <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_rem   <= w_rem_n;
      r_addr  <= w_addr_n;
      r_b     <= w_b_n;
      r_error <= w_error_n;
      r_done  <= w_done_n;
    end
  end

endmodule
